// File: rtl/axis_noc_pkt_arbiter.sv
// axis_noc_pkt_arbiter: packet-level round-robin arbiter sharing one AXI4-Stream NoC channel.
// Grant is held from the first beat through tlast; each packet is tagged with its requester index on m_tid.
// Optional feature: define AXIS_NOC_ARB_OUT_REG_EN to register the channel outputs through a 2-entry skid buffer.
module axis_noc_pkt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 256,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int TID_WIDTH   = 6,
    parameter int TDEST_WIDTH = 7,
    parameter int MAX_BEATS   = 64
) (
    input  logic                            aclk,
    input  logic                            arstn,
    input  logic [NUM_REQ-1:0]              s_tvalid,
    output logic [NUM_REQ-1:0]              s_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_REQ-1:0]              s_tlast,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]   s_tkeep,
    input  logic [NUM_REQ*TDEST_WIDTH-1:0]  s_tdest,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [KEEP_WIDTH-1:0]           m_tkeep,
    output logic                            m_tlast,
    output logic [TDEST_WIDTH-1:0]          m_tdest,
    output logic [TID_WIDTH-1:0]            m_tid,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            err_overlong
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + TDEST_WIDTH + TID_WIDTH;

    typedef enum logic {IDLE, PKT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        g_q, g_d, last_q, last_d, idx;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 found;
    logic [PW-1:0]        in_pl;
    logic                 in_v, in_last, rdy, xfer;

    // Payload of the granted requester; zero while idle so tid/tlast read 0 between packets
    always_comb begin
        in_pl   = '0;
        in_v    = 1'b0;
        in_last = 1'b0;
        if (state_q == PKT) begin
            in_v    = s_tvalid[g_q];
            in_last = s_tlast[g_q];
            in_pl   = {s_tdata[int'(g_q)*DATA_WIDTH +: DATA_WIDTH],
                       s_tkeep[int'(g_q)*KEEP_WIDTH +: KEEP_WIDTH],
                       in_last,
                       s_tdest[int'(g_q)*TDEST_WIDTH +: TDEST_WIDTH],
                       TID_WIDTH'(g_q)};
        end
    end

    assign xfer     = in_v & rdy;
    assign s_tready = (state_q == PKT && rdy) ? grant_q : '0;
    assign grant    = grant_q;
    assign err_overlong = err_q;

    // Round-robin pick in IDLE, packet tracking and overlong detection in PKT
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        found   = 1'b0;
        idx     = '0;
        if (state_q == IDLE) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = IW'((int'(last_q) + i) % NUM_REQ);
                if (!found && s_tvalid[idx]) begin
                    found = 1'b1;
                    g_d   = idx;
                end
            end
            if (found) begin
                state_d = PKT;
                grant_d = NUM_REQ'(1) << g_d;
                cnt_d   = '0;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 16'd1;
            if (!in_last && cnt_q == 16'(MAX_BEATS - 1)) err_d = 1'b1;
            if (in_last) begin
                state_d = IDLE;
                last_d  = g_q;
                grant_d = '0;
            end
        end
    end

    // Arbiter state registers
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef AXIS_NOC_ARB_OUT_REG_EN
    logic [PW-1:0] out_q, out_d, skid_q, skid_d;
    logic          out_v_q, out_v_d, skid_v_q, skid_v_d;

    // Requester sees ready as long as the skid slot is free, so m_tready never reaches s_tready
    assign rdy = ~skid_v_q;

    // Output slot refills from the skid slot first, otherwise from the incoming beat
    always_comb begin
        out_d    = out_q;
        out_v_d  = out_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (!out_v_q || m_tready) begin
            if (skid_v_q) begin
                out_d    = skid_q;
                out_v_d  = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                out_v_d = xfer;
                if (xfer) out_d = in_pl;
            end
        end else if (xfer) begin
            skid_d   = in_pl;
            skid_v_d = 1'b1;
        end
    end

    // Skid buffer registers; reset empties both slots
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign m_tvalid = out_v_q;
    assign {m_tdata, m_tkeep, m_tlast, m_tdest, m_tid} = out_q;
`else
    assign rdy      = m_tready;
    assign m_tvalid = in_v;
    assign {m_tdata, m_tkeep, m_tlast, m_tdest, m_tid} = in_pl;
`endif

endmodule

// File: tb/tb_axis_noc_pkt_arbiter.sv
// tb_axis_noc_pkt_arbiter: table-driven bench for axis_noc_pkt_arbiter (4 requesters, 16-bit data, MAX_BEATS=4).
module tb_axis_noc_pkt_arbiter;

    localparam int NR = 4, DW = 16, KW = 2, TW = 6, DSW = 7;

    logic              aclk = 1'b0, arstn = 1'b0;
    logic [NR-1:0]     s_tvalid = '0, s_tready, s_tlast = '0, grant;
    logic [NR*DW-1:0]  s_tdata = '0;
    logic [NR*KW-1:0]  s_tkeep = '0;
    logic [NR*DSW-1:0] s_tdest = '0;
    logic              m_tvalid, m_tready = 1'b1, m_tlast, err_overlong;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [DSW-1:0]    m_tdest;
    logic [TW-1:0]     m_tid;

    int checks = 0, errors = 0;

    axis_noc_pkt_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TID_WIDTH(TW),
                           .TDEST_WIDTH(DSW), .MAX_BEATS(4)) dut (
        .aclk(aclk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tdest(s_tdest), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tdest(m_tdest), .m_tid(m_tid), .grant(grant), .err_overlong(err_overlong));

    always #5 aclk = ~aclk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  tv, tl;
        logic        mr;
        logic [11:0] dat;
        logic [3:0]  gr, sr;
        logic        mv;
        logic [5:0]  tid;
        logic        last, err;
        logic [11:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic [3:0] tv, input logic [3:0] tl, input logic mr,
                       input logic [11:0] dat, input logic [3:0] gr, input logic [3:0] sr,
                       input logic mv, input int tid, input logic last, input logic err,
                       input logic [11:0] ed);
        tbl.push_back('{rst_n, tv, tl, mr, dat, gr, sr, mv, 6'(tid), last, err, ed});
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] dat);
        for (int r = 0; r < NR; r++) begin
            s_tdata[r*DW +: DW]   = {4'(r), dat};
            s_tkeep[r*KW +: KW]   = {1'b1, 1'(r)};
            s_tdest[r*DSW +: DSW] = 7'(r + 8);
        end
    endtask

    initial begin
        vec_t v;
`ifndef AXIS_NOC_ARB_OUT_REG_EN
        // two simultaneous 3-beat packets: requester 0 first, bubble, then requester 2
        add(1, 4'b0101, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0101, 4'b0000, 1, 12'h010, 4'b0001, 4'b0001, 1, 0, 0, 0, 12'h010);
        add(1, 4'b0101, 4'b0000, 1, 12'h011, 4'b0001, 4'b0001, 1, 0, 0, 0, 12'h011);
        add(1, 4'b0101, 4'b0001, 1, 12'h012, 4'b0001, 4'b0001, 1, 0, 1, 0, 12'h012);
        add(1, 4'b0100, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0100, 4'b0000, 1, 12'h020, 4'b0100, 4'b0100, 1, 2, 0, 0, 12'h020);
        add(1, 4'b0100, 4'b0000, 1, 12'h021, 4'b0100, 4'b0100, 1, 2, 0, 0, 12'h021);
        add(1, 4'b0100, 4'b0100, 1, 12'h022, 4'b0100, 4'b0100, 1, 2, 1, 0, 12'h022);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(0, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        // all requesters offering 1-beat packets: grants 0,1,2,3,0,1 with a bubble between
        for (int k = 0; k < 6; k++) begin
            add(1, 4'b1111, 4'b1111, 1, 12'(12'h030 + 2*k), 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
            add(1, 4'b1111, 4'b1111, 1, 12'(12'h031 + 2*k), 4'(1 << (k % 4)), 4'(1 << (k % 4)),
                1, k % 4, 1, 0, 12'(12'h031 + 2*k));
        end
        // requester 1 under toggling backpressure; requester 3 waits for tlast
        add(1, 4'b0010, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b1010, 4'b0000, 1, 12'h110, 4'b0010, 4'b0010, 1, 1, 0, 0, 12'h110);
        add(1, 4'b1010, 4'b0000, 0, 12'h111, 4'b0010, 4'b0000, 1, 1, 0, 0, 12'h111);
        add(1, 4'b1010, 4'b0000, 1, 12'h111, 4'b0010, 4'b0010, 1, 1, 0, 0, 12'h111);
        add(1, 4'b1010, 4'b0000, 0, 12'h112, 4'b0010, 4'b0000, 1, 1, 0, 0, 12'h112);
        add(1, 4'b1010, 4'b1010, 1, 12'h112, 4'b0010, 4'b0010, 1, 1, 1, 0, 12'h112);
        add(1, 4'b1000, 4'b1000, 1, 12'h130, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b1000, 4'b1000, 1, 12'h131, 4'b1000, 4'b1000, 1, 3, 1, 0, 12'h131);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        // exactly MAX_BEATS beats: no error
        add(1, 4'b0001, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        for (int b = 0; b < 4; b++)
            add(1, 4'b0001, (b == 3) ? 4'b0001 : 4'b0000, 1, 12'(12'h200 + b), 4'b0001, 4'b0001,
                1, 0, b == 3, 0, 12'(12'h200 + b));
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        // MAX_BEATS+1 beats: error visible from the 5th beat on, sticky afterwards
        add(1, 4'b0001, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        for (int b = 0; b < 5; b++)
            add(1, 4'b0001, (b == 4) ? 4'b0001 : 4'b0000, 1, 12'(12'h300 + b), 4'b0001, 4'b0001,
                1, 0, b == 4, b == 4, 12'(12'h300 + b));
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 1, 12'h000);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 1, 12'h000);
        // reset on beat 2 of a 4-beat packet from requester 2, then requester 0 wins
        add(1, 4'b0100, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 1, 12'h000);
        add(1, 4'b0100, 4'b0000, 1, 12'h400, 4'b0100, 4'b0100, 1, 2, 0, 1, 12'h400);
        add(0, 4'b0100, 4'b0000, 1, 12'h401, 4'b0100, 4'b0100, 1, 2, 0, 1, 12'h401);
        add(1, 4'b0101, 4'b0001, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0101, 4'b0001, 1, 12'h500, 4'b0001, 4'b0001, 1, 0, 1, 0, 12'h500);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
`else
        // first scenario through the skid buffer: same order, one cycle later
        add(1, 4'b0101, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0101, 4'b0000, 1, 12'h010, 4'b0001, 4'b0001, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0101, 4'b0000, 1, 12'h011, 4'b0001, 4'b0001, 1, 0, 0, 0, 12'h010);
        add(1, 4'b0101, 4'b0001, 1, 12'h012, 4'b0001, 4'b0001, 1, 0, 0, 0, 12'h011);
        add(1, 4'b0100, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 1, 0, 1, 0, 12'h012);
        add(1, 4'b0100, 4'b0000, 1, 12'h020, 4'b0100, 4'b0100, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0100, 4'b0000, 1, 12'h021, 4'b0100, 4'b0100, 1, 2, 0, 0, 12'h020);
        add(1, 4'b0100, 4'b0100, 1, 12'h022, 4'b0100, 4'b0100, 1, 2, 0, 0, 12'h021);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 1, 2, 1, 0, 12'h022);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        // stalled channel: s_tready drops only once two beats sit in the buffer
        add(1, 4'b0010, 4'b0000, 0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0010, 4'b0000, 0, 12'h101, 4'b0010, 4'b0010, 0, 0, 0, 0, 12'h000);
        add(1, 4'b0010, 4'b0000, 0, 12'h102, 4'b0010, 4'b0010, 1, 1, 0, 0, 12'h101);
        add(1, 4'b0010, 4'b0000, 0, 12'h103, 4'b0010, 4'b0000, 1, 1, 0, 0, 12'h101);
        add(1, 4'b0010, 4'b0000, 1, 12'h103, 4'b0010, 4'b0000, 1, 1, 0, 0, 12'h101);
        add(1, 4'b0010, 4'b0010, 1, 12'h103, 4'b0010, 4'b0010, 1, 1, 0, 0, 12'h102);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 1, 1, 1, 0, 12'h103);
        add(1, 4'b0000, 4'b0000, 1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 12'h000);
`endif
        // hand-written reset sequence and reset-state checks
        drive(12'h000);
        repeat (2) @(posedge aclk);
        #1 arstn = 1'b1;
        #2;
        chk("reset_grant", -1, 32'(grant), 0);
        chk("reset_s_tready", -1, 32'(s_tready), 0);
        chk("reset_m_tvalid", -1, 32'(m_tvalid), 0);
        chk("reset_m_tid", -1, 32'(m_tid), 0);
        chk("reset_m_tlast", -1, 32'(m_tlast), 0);
        chk("reset_err", -1, 32'(err_overlong), 0);
        @(posedge aclk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            arstn    = v.rst_n;
            s_tvalid = v.tv;
            s_tlast  = v.tl;
            m_tready = v.mr;
            drive(v.dat);
            #2;
            chk("grant", i, 32'(grant), 32'(v.gr));
            chk("s_tready", i, 32'(s_tready), 32'(v.sr));
            chk("m_tvalid", i, 32'(m_tvalid), 32'(v.mv));
            chk("err_overlong", i, 32'(err_overlong), 32'(v.err));
            if (v.mv) begin
                chk("m_tid", i, 32'(m_tid), 32'(v.tid));
                chk("m_tlast", i, 32'(m_tlast), 32'(v.last));
                chk("m_tdata", i, 32'(m_tdata), 32'({v.tid[3:0], v.ed}));
                chk("m_tkeep", i, 32'(m_tkeep), 32'({1'b1, v.tid[0]}));
                chk("m_tdest", i, 32'(m_tdest), 32'(7'(v.tid + 8)));
            end
            @(posedge aclk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_noc_pkt_arbiter.md
# axis_noc_pkt_arbiter

Packet-level round-robin arbiter that shares one 256-bit AXI4-Stream NoC ingress channel of the 4x256 to 8x128 segmented converter between NUM_REQ requester streams. Grant is held for a whole packet, from the first beat through the tlast beat, so packets never interleave on the channel. Each packet is tagged with its requester index on tid. One instance sits in front of each NoC channel input.

## Interface

Parameters:

- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 256: tdata width.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- TID_WIDTH, 6: output tid width; must be >= clog2(NUM_REQ).
- TDEST_WIDTH, 7: tdest width.
- MAX_BEATS, 64: longest legal packet in beats; range 1..65535.

Ports:

- aclk, in, 1: sole clock.
- arstn, in, 1: reset, synchronous, active-low.
- s_tvalid, in, NUM_REQ: requester valid, bit r belongs to requester r.
- s_tready, out, NUM_REQ: requester ready.
- s_tdata, in, NUM_REQ*DATA_WIDTH: flattened, requester r at slice [r*DATA_WIDTH +: DATA_WIDTH].
- s_tlast, in, NUM_REQ: requester last.
- s_tkeep, in, NUM_REQ*KEEP_WIDTH: flattened like s_tdata.
- s_tdest, in, NUM_REQ*TDEST_WIDTH: flattened like s_tdata.
- m_tvalid / m_tready, out / in, 1: channel handshake.
- m_tdata, m_tkeep, m_tlast, m_tdest, out, widths as above: channel payload.
- m_tid, out, TID_WIDTH: zero-extended index of the granted requester.
- grant, out, NUM_REQ: one-hot current grant; all zero when idle.
- err_overlong, out, 1: sticky, set when a packet exceeds MAX_BEATS.

## Operation

- FSM has two states, IDLE and PKT.
- IDLE:
  - All s_tready are 0. m_tvalid is 0 when the output register is absent.
  - If any s_tvalid is 1, select the first requester with valid set, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - Register the selection into grant and go to PKT.
- PKT, with granted requester g:
  - s_tready[g] = m_tready; every other s_tready is 0.
  - m_tvalid = s_tvalid[g].
  - m_tdata, m_tkeep, m_tlast and m_tdest come from slice g; m_tid = g.
  - A beat transfers when s_tvalid[g] and s_tready[g] are both 1.
  - On a transferring beat with tlast: set last_grant to g, clear grant, return to IDLE.
- Requesters that drop tvalid while not granted lose nothing; arbitration samples tvalid only in IDLE.
- Beat counter, 16 bits:
  - Cleared on entry to PKT; increments on each transferring beat.
  - If a non-last beat transfers while the counter equals MAX_BEATS-1, set err_overlong.
  - The packet still passes intact; it is not truncated.
  - err_overlong clears only on reset.
- Reset state:
  - FSM in IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - grant = 0, s_tready = 0, m_tvalid = 0, m_tid = 0, m_tlast = 0, err_overlong = 0, beat counter = 0.
- Reset asserted mid-packet abandons the packet. The downstream channel sees a truncated packet; the converter's err_alignment reports it.

## Timing

- Arbitration takes one cycle:
  - The first s_tvalid seen in IDLE at cycle N gives grant at N+1.
  - The first beat can transfer at N+1, or at N+2 when the output register is present.
- One idle bubble follows every tlast.
  - Peak utilisation with back-to-back packets of L beats is L/(L+1).
- No combinational path from s_tvalid to any s_tready.
- Without the output register, m_tready reaches s_tready[g] through combinational logic.

## Configuration

- Macro: AXIS_NOC_ARB_OUT_REG_EN.
- Defined:
  - A 2-entry skid buffer registers m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest and m_tid.
  - s_tready[g] is driven by the buffer's not-full flag, never by m_tready.
  - Adds 1 cycle of latency; full throughput within a packet.
  - The FSM leaves PKT when tlast enters the buffer.
  - Reset empties the buffer.
- Undefined: combinational pass-through exactly as described in Operation.

## Test plan

- Reset, then requesters 0 and 2 each present one 3-beat packet together, m_tready=1:
  - Requester 0's packet appears first, then one bubble, then requester 2's.
  - m_tid is 0 for the first packet and 2 for the second; grant goes 0001 -> 0000 -> 0100.
- All 4 requesters offer 1-beat packets continuously:
  - Grant order is 0,1,2,3,0,1.
  - A beat transfers every other cycle.
- Requester 1 mid-packet with m_tready toggling 1,0,1,0:
  - Data holds stable while m_tready=0.
  - Requester 3's valid is ignored until requester 1's tlast.
- MAX_BEATS=4 and a 5-beat packet:
  - err_overlong rises on the 5th beat and stays 1 after the packet.
  - All 5 beats are delivered.
- arstn=0 for one cycle on beat 2 of a 4-beat packet:
  - The next cycle shows grant=0, s_tready=0, m_tvalid=0 and err_overlong=0.
  - The next grant goes to requester 0 if it is valid.
- With AXIS_NOC_ARB_OUT_REG_EN defined, the first scenario is repeated:
  - Same data and order, every beat delayed by 1 cycle.
  - While m_tready=0, the requester sees s_tready fall only after 2 beats are buffered.
